// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request/status handshake and PS/2 line bundle for ps2_host_tx.
// master = host-side user and line model, slave = the transmitter.
interface ps2_host_tx_if;
   logic [1:0] ps2;
   logic [1:0] ps2_oe;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output ps2,
      output tx_data,
      output tx_start,
      input  ps2_oe,
      input  busy,
      input  done,
      input  error
   );

   modport slave (
      input  ps2,
      input  tx_data,
      input  tx_start,
      output ps2_oe,
      output busy,
      output done,
      output error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-clock frame, ACK).
// Optional macro PS2_TX_FILTER_EN adds an 8-sample glitch filter on the PS/2 clock line.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_TICKS = 480,
   parameter int unsigned TIMEOUT_TICKS = 60000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         ce,
   ps2_host_tx_if.slave bus
);

   localparam int unsigned MAX_TICKS = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
   localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_TICKS - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      XMIT,
      ACK,
      RELEASE
   } state_t;

   state_t           state;
   logic [1:0]       oe_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_idx;
   logic [8:0]       shreg;

   logic [1:0]       sync_a;
   logic [1:0]       sync_q;
   logic             clk_prev;
   logic             dat_filt;
   logic             fall_c;
   logic             tmo_c;

   // Two-flop synchronisers for both lines; released lines read as ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a <= 2'b11;
         sync_q <= 2'b11;
      end else if (ce) begin
         sync_a <= bus.ps2;
         sync_q <= sync_a;
      end
   end

`ifdef PS2_TX_FILTER_EN
   logic [7:0] clk_hist;
   logic       clk_filt;

   // Clock level only moves once eight consecutive samples agree.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_hist <= '1;
         clk_filt <= 1'b1;
      end else if (ce) begin
         clk_hist <= {clk_hist[6:0], sync_q[0]};
         if (&clk_hist) begin
            clk_filt <= 1'b1;
         end else if (~|clk_hist) begin
            clk_filt <= 1'b0;
         end
      end
   end
`else
   logic clk_filt;
   assign clk_filt = sync_q[0];
`endif

   assign dat_filt = sync_q[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_prev <= 1'b1;
      end else if (ce) begin
         clk_prev <= clk_filt;
      end
   end

   assign fall_c = clk_prev & ~clk_filt;
   assign tmo_c  = ~fall_c & (cnt == TMO_LAST);

   // Transfer sequencer; done/error are single-clock pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         oe_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (ce) begin
            case (state)
               IDLE: begin
                  oe_q   <= 2'b00;
                  busy_q <= 1'b0;
                  if (bus.tx_start) begin
                     shreg   <= {~^bus.tx_data, bus.tx_data};
                     cnt     <= '0;
                     bit_idx <= '0;
                     oe_q    <= 2'b01;
                     busy_q  <= 1'b1;
                     state   <= INHIBIT;
                  end
               end

               INHIBIT: begin
                  if (cnt == INH_LAST) begin
                     cnt   <= '0;
                     oe_q  <= 2'b11;
                     state <= REQ;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               REQ: begin
                  oe_q    <= 2'b10;
                  bit_idx <= '0;
                  cnt     <= '0;
                  state   <= XMIT;
               end

               // shreg shifts in ones so the tenth edge naturally releases data (stop bit).
               XMIT: begin
                  if (fall_c) begin
                     cnt     <= '0;
                     oe_q    <= {~shreg[0], 1'b0};
                     shreg   <= {1'b1, shreg[8:1]};
                     bit_idx <= bit_idx + 4'd1;
                     if (bit_idx == 4'd9) begin
                        state <= ACK;
                     end
                  end else if (tmo_c) begin
                     oe_q    <= 2'b00;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                     cnt     <= '0;
                     state   <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               ACK: begin
                  if (fall_c) begin
                     cnt <= '0;
                     if (!dat_filt) begin
                        state <= RELEASE;
                     end else begin
                        oe_q    <= 2'b00;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state   <= IDLE;
                     end
                  end else if (tmo_c) begin
                     oe_q    <= 2'b00;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                     cnt     <= '0;
                     state   <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               RELEASE: begin
                  if (tmo_c) begin
                     oe_q    <= 2'b00;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                     cnt     <= '0;
                     state   <= IDLE;
                  end else if (clk_filt && dat_filt) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                     cnt    <= '0;
                     state  <= IDLE;
                  end else if (fall_c) begin
                     cnt <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               default: begin
                  oe_q   <= 2'b00;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ps2_oe = oe_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.error  = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model driving ps2_host_tx; a scoreboard queue of
// expected outcomes is drained by a monitor that compares each done/error pulse and captured frame.
module tb_ps2_host_tx;
   localparam int unsigned INH = 480;
   localparam int unsigned TMO = 1000;
   localparam int          H   = 30;
`ifdef PS2_TX_FILTER_EN
   localparam int          TMO_LAT = int'(TMO) + 12;
`else
   localparam int          TMO_LAT = int'(TMO) + 3;
`endif

   typedef struct {
      logic [7:0] data;
      int         kind;   // 0 ack -> done, 1 nack -> error, 2 timeout -> error
   } exp_t;

   logic clock;
   logic reset;
   logic ce = 1'b0;
   logic dev_clk;
   logic dev_dat;
   logic done_q = 1'b0;
   logic [1:0] oe_prev = 2'b00;
   int   inh_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] d;
   logic       c;

   exp_t       exp_q[$];
   logic [9:0] obs_q[$];

   ps2_host_tx_if bus ();

   // Open-drain resolution of the two PS/2 lines.
   assign bus.ps2 = {dev_dat & ~bus.ps2_oe[1], dev_clk & ~bus.ps2_oe[0]};

   ps2_host_tx #(
      .INHIBIT_TICKS(INH),
      .TIMEOUT_TICKS(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .ce   (ce),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) ce <= ($urandom_range(3) != 0);

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Frame as seen by the device: data LSB first, odd parity, stop bit.
   function automatic logic [9:0] ref_frame(input logic [7:0] v);
      int ones;
      ones = $countones(v);
      return {1'b1, ((ones % 2) == 0), v};
   endfunction

   // Scoreboard monitor.
   always @(negedge clock) begin
      exp_t       e;
      logic [9:0] f;
      if (!reset) begin
         if (bus.done && bus.error) chk("done_error_excl", 1, 0);
         if (done_q && bus.done) chk("done_pulse_width", 2, 1);
         if (bus.done || bus.error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", bus.done ? 1 : 2, 0);
            end else begin
               e = exp_q.pop_front();
               chk("outcome_error", int'(bus.error), (e.kind != 0) ? 1 : 0);
               if (bus.done) chk("busy_at_done", int'(bus.busy), 0);
               else          chk("oe_at_error", int'(bus.ps2_oe), 0);
               if (e.kind != 2) begin
                  if (obs_q.size() == 0) begin
                     chk("frame_missing", 0, 1);
                  end else begin
                     f = obs_q.pop_front();
                     chk("frame", int'(f), int'(ref_frame(e.data)));
                  end
               end
            end
         end
      end
      done_q <= bus.done;
   end

   // Inhibit length: ce ticks spent with ps2_oe=01 before it turns to 11.
   always @(negedge clock) begin
      if (reset) begin
         inh_cnt = 0;
      end else begin
         if (bus.ps2_oe == 2'b01 && ce) inh_cnt++;
         if (oe_prev == 2'b01 && bus.ps2_oe == 2'b11) chk("inhibit_ticks", inh_cnt, int'(INH));
         if (bus.ps2_oe != 2'b01) inh_cnt = 0;
      end
      oe_prev = bus.ps2_oe;
   end

   task automatic wait_line(input string name, input logic [1:0] lv);
      int t;
      t = 0;
      while (bus.ps2 !== lv && t < 3000) begin
         @(negedge clock);
         t++;
      end
      chk(name, int'(bus.ps2), int'(lv));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int t;
      t = 0;
      while (bus.busy && t < budget) begin
         @(negedge clock);
         t++;
      end
      chk(name, int'(bus.busy), 0);
   endtask

   task automatic send(input logic [7:0] v, input int kind, input bit spam);
      exp_t e;
      int   t;
      @(negedge clock);
      bus.tx_data  = v;
      bus.tx_start = 1'b1;
      if (kind < 3) begin
         e.data = v;
         e.kind = kind;
         exp_q.push_back(e);
      end
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!bus.busy && t < 20);
      chk("accept", int'(bus.busy), 1);
      bus.tx_start = 1'b0;
      if (spam) begin
         repeat (4) @(negedge clock);
         bus.tx_data  = ~v;
         bus.tx_start = 1'b1;
         repeat (8) @(negedge clock);
         bus.tx_start = 1'b0;
      end
   endtask

   // Device: 0 ack, 1 nack, 2 stall after edge 4, 3 host reset at edge 6, 4 clock glitch + ack.
   task automatic device(input int mode);
      logic [9:0] bits;
      int         n;
      bits = '0;
      wait_line("dev_inhibit", 2'b10);
      wait_line("dev_request", 2'b01);
      repeat (H) @(negedge clock);
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         if (mode == 2 && k == 4) begin
            n = 0;
            for (int t = 0; t < 3000; t++) begin
               if (ce) n++;
               @(negedge clock);
               if (t == H) dev_clk = 1'b1;
               if (bus.error) break;
            end
            dev_clk = 1'b1;
            chk("timeout_ticks", n, TMO_LAT);
            return;
         end
         if (mode == 3 && k == 6) begin
            repeat (8) @(negedge clock);
            chk("busy_before_reset", int'(bus.busy), 1);
            reset = 1'b1;
            #1;
            chk("oe_on_reset", int'(bus.ps2_oe), 0);
            chk("busy_on_reset", int'(bus.busy), 0);
            dev_clk = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            return;
         end
         repeat (H) @(negedge clock);
         dev_clk = 1'b1;
         if (mode == 4 && k == 3) begin
            repeat (H / 2) @(negedge clock);
            dev_clk = 1'b0;
            repeat (3) @(negedge clock);
            dev_clk = 1'b1;
            repeat (H - H / 2 - 3) @(negedge clock);
         end else begin
            repeat (H) @(negedge clock);
         end
         if (k <= 10) bits[k-1] = bus.ps2[1];
         if (k == 10) begin
            obs_q.push_back(bits);
            dev_dat = (mode == 1);
            repeat (4) @(negedge clock);
         end
      end
      dev_dat = 1'b1;
   endtask

   initial begin
      reset        = 1'b1;
      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;
      dev_clk      = 1'b1;
      dev_dat      = 1'b1;
      repeat (4) @(negedge clock);
      chk("rst_oe", int'(bus.ps2_oe), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_error", int'(bus.error), 0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      send(8'hED, 0, 1'b0); device(0); wait_idle("idle_ed", 200);
      send(8'hF4, 0, 1'b1); device(0); wait_idle("idle_f4", 200);
      send(8'hFF, 1, 1'b0); device(1); wait_idle("idle_nack", 200);
      chk("oe_after_nack", int'(bus.ps2_oe), 0);

      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         send(d, 0, (i % 2) == 1);
         device(0);
         wait_idle("idle_rand", 200);
      end

      // Back-to-back: request raised the moment busy drops must be taken on the next ce tick.
      d = 8'($urandom);
      send(d, 0, 1'b0);
      device(0);
      for (int t = 0; t < 200 && bus.busy; t++) @(negedge clock);
      d = 8'($urandom);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      exp_q.push_back('{data: d, kind: 0});
      for (int t = 0; t < 20; t++) begin
         c = ce;
         @(negedge clock);
         if (c) break;
      end
      chk("reaccept", int'(bus.busy), 1);
      bus.tx_start = 1'b0;
      device(0);
      wait_idle("idle_reaccept", 200);

      send(8'($urandom), 2, 1'b0); device(2); wait_idle("idle_tmo", 100);
      chk("oe_after_tmo", int'(bus.ps2_oe), 0);

      send(8'($urandom), 3, 1'b0); device(3);
      repeat (4) @(negedge clock);
      send(8'h55, 0, 1'b0); device(0); wait_idle("idle_55", 200);

`ifdef PS2_TX_FILTER_EN
      send(8'hA5, 0, 1'b0); device(4); wait_idle("idle_glitch", 200);
`endif

      repeat (10) @(negedge clock);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("obs_q_empty", obs_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_TICKS, default 480, ce ticks of clock-line inhibit before the start bit (120 us at 4 MHz ce).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 60000, maximum ce ticks between device clock falling edges before abort.
REQ-003 SHALL have port clock, input, 1, system clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ce, input, 1, clock enable; all state advances only when ce=1.
REQ-006 SHALL have port ps2, input, 2, line levels: [0] PS/2 clock, [1] PS/2 data.
REQ-007 SHALL have port ps2_oe, output, 2, open-drain pull-low enables: [0] clock, [1] data; 1 = drive low.
REQ-008 SHALL have port tx_data, input, 8, byte to send.
REQ-009 SHALL have port tx_start, input, 1, request; sampled on ce ticks.
REQ-010 SHALL have port busy, output, 1, high from accept to return to IDLE.
REQ-011 SHALL have port done, output, 1, one-clock pulse on ACK received.
REQ-012 SHALL have port error, output, 1, one-clock pulse on NACK or timeout.

Function
REQ-013 SHALL detect device clock falling edge on filtered ps2[0]: filtered level goes 1->0.
REQ-014 SHALL use states IDLE, INHIBIT, REQ, XMIT, ACK, RELEASE.
REQ-015 IDLE: ps2_oe=00, busy=0; tx_start=1 latches tx_data, computes odd parity (parity = ~^tx_data), clears counters, enters INHIBIT.
REQ-016 INHIBIT: ps2_oe=01; counter increments per ce tick; at INHIBIT_TICKS-1 sets ps2_oe=11 and enters REQ.
REQ-017 REQ: after exactly one ce tick with ps2_oe=11, sets ps2_oe[0]=0 (clock released, data held low = start bit), enters XMIT, bit index=0.
REQ-018 XMIT: on falling edges 1-8 drive data bits 0-7 LSB first, edge 9 parity, edge 10 stop (ps2_oe[1]=0); ps2_oe[1] = ~bit; after edge 10 enter ACK.
REQ-019 ACK: on next falling edge sample filtered ps2[1]; 0 -> enter RELEASE with ack flag; 1 -> pulse error, enter IDLE.
REQ-020 RELEASE: wait until filtered ps2[0]=1 and ps2[1]=1, then pulse done, enter IDLE.
REQ-021 Timeout counter SHALL clear on every falling edge and on entry to XMIT; in XMIT/ACK/RELEASE reaching TIMEOUT_TICKS-1 forces ps2_oe=00, pulses error, enters IDLE.
REQ-022 tx_start while busy=1 SHALL be ignored; no queuing.
REQ-023 done and error SHALL never assert in the same cycle.
REQ-024 Re-accept SHALL be possible on the first ce tick after return to IDLE.

Reset
REQ-025 reset SHALL asynchronously force IDLE, ps2_oe=00, busy=0, done=0, error=0, counters=0, filter state=all-ones (lines released), even mid-transfer.

Configuration
REQ-026 Macro PS2_TX_FILTER_EN defined: ps2[0] passes an 8-sample ce shift filter; level changes only when all 8 samples agree; ps2[1] two-stage synchronised.
REQ-027 Macro PS2_TX_FILTER_EN undefined: both lines two-flop synchronised only, no filter; edge latency 2 ce ticks.

Verification
REQ-028 tx_data=0xED, device model clocks 10 kHz, ACKs -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done one pulse, busy low after RELEASE.
REQ-029 tx_data=0xF4 -> parity bit 0 observed at edge 9; inhibit phase ps2_oe=01 lasts exactly 480 ce ticks.
REQ-030 Device holds data high at ACK edge for tx_data=0xFF -> error pulse, done never asserted, ps2_oe=00.
REQ-031 Device stops clocking after edge 4 -> error after 60000 ce ticks, ps2_oe=00, busy=0.
REQ-032 reset pulse during XMIT edge 6 -> ps2_oe=00 same cycle, busy=0; next tx_start=0x55 completes normally.
REQ-033 With PS2_TX_FILTER_EN, 3-tick low glitch on ps2[0] during XMIT -> no bit advance; transfer completes with correct bits.
